// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sequential single-MAC convolution controller, one tap per cycle
// Optional CONV_SEQ_SATURATE_EN: saturate out_data instead of keeping the low bits.
module conv_seq_ctrl #(
    parameter int N            = 5,
    parameter int C            = 1,
    parameter int F            = 3,
    parameter int S            = 1,
    parameter int P            = 0,
    parameter int bias         = 0,
    parameter int indatawidth  = 8,
    parameter int outdatawidth = 8,
    localparam int O  = (N - F + 2 * P) / S + 1,
    localparam int NW = (N > 1) ? $clog2(N) : 1,
    localparam int FW = (F > 1) ? $clog2(F) : 1,
    localparam int CW = $clog2(C) | 1,
    localparam int OW = (O > 1) ? $clog2(O) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    img_rd_en,
    output logic [NW-1:0]           img_row,
    output logic [NW-1:0]           img_col,
    output logic [CW-1:0]           img_ch,
    input  logic [indatawidth-1:0]  img_data,
    output logic                    flt_rd_en,
    output logic [FW-1:0]           flt_row,
    output logic [FW-1:0]           flt_col,
    output logic [CW-1:0]           flt_ch,
    input  logic [indatawidth-1:0]  flt_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [outdatawidth-1:0] out_data,
    output logic [OW-1:0]           out_row,
    output logic [OW-1:0]           out_col
);

    localparam int ACCW = 2 * indatawidth + $clog2(F * F * C) + 1;
    localparam int SW   = ((ACCW > 32) ? ACCW : 32) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, LAST, EMIT} state_t;

    state_t                      state, state_nxt;
    logic [FW-1:0]               i_f, j_f;
    logic [CW-1:0]               k;
    logic [OW-1:0]               i_o, j_o;
    logic                        inr_q;
    logic [ACCW-1:0]             acc, acc_nxt;
    logic [2*indatawidth-1:0]    prod;
    logic [outdatawidth-1:0]     red;
    logic                        last_tap, last_out, hs, in_range;
    int                          r, c;

    assign last_tap = (i_f == FW'(F - 1)) && (j_f == FW'(F - 1)) && (k == CW'(C - 1));
    assign last_out = (i_o == OW'(O - 1)) && (j_o == OW'(O - 1));
    assign hs       = (state == EMIT) && out_ready;

    // Padding taps land at negative or >=N coordinates and are never read.
    always_comb begin
        r        = int'(i_o) * S + int'(i_f) - P;
        c        = int'(j_o) * S + int'(j_f) - P;
        in_range = (r >= 0) && (r < N) && (c >= 0) && (c < N);
    end

    // The final tap's product arrives during LAST, so fold it in before reducing.
    always_comb begin
        prod    = img_data * flt_data;
        acc_nxt = acc + (inr_q ? ACCW'(prod) : '0);
    end

`ifdef CONV_SEQ_SATURATE_EN
    logic [SW-1:0] sum;
    always_comb begin
        sum = SW'(acc_nxt) + SW'(bias);
        red = (|sum[SW-1:outdatawidth]) ? '1 : sum[outdatawidth-1:0];
    end
`else
    always_comb begin
        red = outdatawidth'(acc_nxt) + outdatawidth'(bias);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (last_tap) state_nxt = LAST;
            LAST:    state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_out ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == EMIT);
        flt_rd_en = (state == FETCH);
        img_rd_en = (state == FETCH) && in_range;
        img_row   = r[NW-1:0];
        img_col   = c[NW-1:0];
        img_ch    = k;
        flt_row   = i_f;
        flt_col   = j_f;
        flt_ch    = k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_f      <= '0;
            j_f      <= '0;
            k        <= '0;
            i_o      <= '0;
            j_o      <= '0;
            inr_q    <= 1'b0;
            acc      <= '0;
            done     <= 1'b0;
            out_data <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            inr_q <= (state == FETCH) && in_range;
            done  <= hs && last_out;

            if (state != FETCH && state_nxt == FETCH) begin
                acc <= '0;
            end else begin
                acc <= acc_nxt;
            end

            if (state == FETCH) begin
                if (i_f == FW'(F - 1)) begin
                    i_f <= '0;
                    if (j_f == FW'(F - 1)) begin
                        j_f <= '0;
                        k   <= (k == CW'(C - 1)) ? '0 : k + 1'b1;
                    end else begin
                        j_f <= j_f + 1'b1;
                    end
                end else begin
                    i_f <= i_f + 1'b1;
                end
            end

            if (state == LAST) begin
                out_data <= red;
                out_row  <= i_o;
                out_col  <= j_o;
            end

            if (hs) begin
                if (i_o == OW'(O - 1)) begin
                    i_o <= '0;
                    j_o <= (j_o == OW'(O - 1)) ? '0 : j_o + 1'b1;
                end else begin
                    i_o <= i_o + 1'b1;
                end
            end
        end
    end

endmodule
